// File: rtl/deser_pkg.sv
// deser_pkg: shared types and default widths for the deserializer slice.
//   DEF_DATA_W   - default parallel word width / maximum burst length
//   DEF_MOD_W    - default width of the bit-count field
//   deser_word_t - one completed word as stored in the output FIFO
//   deser_state_t- assembler FSM states
package deser_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_MOD_W  = $clog2(DEF_DATA_W);

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_MOD_W-1:0]  mod;
    } deser_word_t;

    typedef enum logic {
        IDLE,
        COLLECT
    } deser_state_t;

endpackage

// File: rtl/deser_fifo.sv
// deser_fifo: synchronous first-word-fall-through FIFO of completed words.
//   clk_i, srst_i   - clock, synchronous active-high reset (pointers only)
//   push, push_word - write request and word; ignored when full unless a pop
//                     happens in the same cycle
//   pop             - consume the head; ignored when empty
//   head            - current head word, all zeros while empty
//   full, empty     - occupancy flags
module deser_fifo
    import deser_pkg::*;
#(
    parameter type word_t     = deser_word_t,
    parameter int  FIFO_DEPTH = 2
) (
    input  logic  clk_i,
    input  logic  srst_i,
    input  logic  push,
    input  word_t push_word,
    input  logic  pop,
    output word_t head,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // One extra pointer bit distinguishes full from empty when the
    // index bits coincide.
    logic [AW:0] wr_ptr_p0;
    logic [AW:0] rd_ptr_p0;
    word_t       mem [FIFO_DEPTH];
    logic        wr_en;
    logic        rd_en;

    assign empty = (wr_ptr_p0 == rd_ptr_p0);
    assign full  = (wr_ptr_p0[AW] != rd_ptr_p0[AW]) &&
                   (wr_ptr_p0[AW-1:0] == rd_ptr_p0[AW-1:0]);

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_comb begin
        head = '0;
        if (!empty) begin
            head = mem[rd_ptr_p0[AW-1:0]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr_p0[AW-1:0]] <= push_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr_p0 <= '0;
            rd_ptr_p0 <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_p0 <= wr_ptr_p0 + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_p0 <= rd_ptr_p0 + 1'b1;
            end
        end
    end

endmodule

// File: rtl/deserializer.sv
// deserializer: collects an MSB-first serial stream into left-aligned words,
// buffers them in a small FWFT FIFO and hands them out over valid/ready.
//   clk_i, srst_i      - clock, synchronous active-high reset
//   ser_data_i         - serial bit, first bit of a burst is the word MSB
//   ser_data_val_i     - serial bit valid; a continuous high run is one burst
//   deser_data_o       - head word, left-aligned, unused low bits zero
//   deser_data_mod_o   - head bit count modulo DATA_W (0 means DATA_W)
//   deser_data_val_o   - head valid
//   deser_data_rdy_i   - consumer takes the head when valid and ready
//   overflow_o         - one-cycle pulse after a completed word was dropped
// DATA_W must be at least 2.
module deserializer
    import deser_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MOD_W      = $clog2(DATA_W),
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              ser_data_i,
    input  logic              ser_data_val_i,
    output logic [DATA_W-1:0] deser_data_o,
    output logic [MOD_W-1:0]  deser_data_mod_o,
    output logic              deser_data_val_o,
    input  logic              deser_data_rdy_i,
    output logic              overflow_o
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [MOD_W-1:0]  mod;
    } word_t;

    // Count held before the final bit of a full-length burst is shifted in.
    localparam logic [MOD_W:0] LAST_CNT = (MOD_W+1)'(DATA_W - 1);

    // Move the first received bit of an n-bit burst up to the word MSB.
    function automatic logic [DATA_W-1:0] left_justify(
        input logic [DATA_W-1:0] v,
        input logic [MOD_W:0]    n
    );
        return v << (DATA_W - int'(n));
    endfunction

    deser_state_t      state_p0;
    logic [DATA_W-1:0] sreg_p0;
    logic [MOD_W:0]    cnt_p0;
    logic              overflow_p1;

    logic [DATA_W-1:0] sreg_next;
    logic              push;
    word_t             push_word;
    word_t             head;
    logic              pop;
    logic              full;
    logic              empty;

    // Stage p0: bit collection and word completion
    always_comb begin
        sreg_next = {sreg_p0[DATA_W-2:0], ser_data_i};
        push      = 1'b0;
        push_word = '0;
        if (state_p0 == COLLECT) begin
            if (ser_data_val_i) begin
                if (cnt_p0 == LAST_CNT) begin
                    push           = 1'b1;
                    push_word.data = sreg_next;
                    push_word.mod  = '0;
                end
            end else begin
                push           = 1'b1;
                push_word.data = left_justify(sreg_p0, cnt_p0);
                push_word.mod  = cnt_p0[MOD_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_p0    <= IDLE;
            sreg_p0     <= '0;
            cnt_p0      <= '0;
            overflow_p1 <= 1'b0;
        end else begin
            overflow_p1 <= push && full && !pop;
            if (state_p0 == IDLE) begin
                if (ser_data_val_i) begin
                    sreg_p0  <= {{(DATA_W-1){1'b0}}, ser_data_i};
                    cnt_p0   <= (MOD_W+1)'(1);
                    state_p0 <= COLLECT;
                end
            end else begin
                if (ser_data_val_i) begin
                    sreg_p0 <= sreg_next;
                    if (cnt_p0 == LAST_CNT) begin
                        cnt_p0   <= '0;
                        state_p0 <= IDLE;
                    end else begin
                        cnt_p0 <= cnt_p0 + 1'b1;
                    end
                end else begin
                    cnt_p0   <= '0;
                    state_p0 <= IDLE;
                end
            end
        end
    end

    // Stage p1: word buffer and output handshake
    assign pop = deser_data_val_o && deser_data_rdy_i;

    deser_fifo #(
        .word_t     (word_t),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .srst_i    (srst_i),
        .push      (push),
        .push_word (push_word),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign deser_data_val_o = !empty;
    assign deser_data_o     = head.data;
    assign deser_data_mod_o = head.mod;
    assign overflow_o       = overflow_p1;

endmodule

// File: tb/tb_deserializer.sv
module tb_deserializer;

    logic        clk = 1'b0;
    logic        srst;
    logic        ser_d;
    logic        ser_v;
    logic        rdy;
    logic [15:0] dout;
    logic [3:0]  dmod;
    logic        dval;
    logic        ovf;

    always #5 clk = ~clk;

    deserializer #(
        .DATA_W     (16),
        .MOD_W      (4),
        .FIFO_DEPTH (2)
    ) dut (
        .clk_i            (clk),
        .srst_i           (srst),
        .ser_data_i       (ser_d),
        .ser_data_val_i   (ser_v),
        .deser_data_o     (dout),
        .deser_data_mod_o (dmod),
        .deser_data_val_o (dval),
        .deser_data_rdy_i (rdy),
        .overflow_o       (ovf)
    );

    typedef struct {
        logic [15:0] data;
        logic [3:0]  mod;
    } exp_t;

    typedef struct {
        logic [15:0] bits;
        int          len;
        logic [15:0] exp_data;
        logic [3:0]  exp_mod;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[7];

    int n_checks = 0;
    int n_pass   = 0;
    int xfer_cnt = 0;
    int ovf_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: every handshake pops one expected word.
    always @(negedge clk) begin
        if (ovf === 1'b1) begin
            ovf_cnt++;
        end
        if (dval === 1'b1 && rdy === 1'b1) begin
            xfer_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_word", sb_q.size(), 1);
            end else begin
                mon_e = sb_q.pop_front();
                check("word_data", {16'h0, dout}, {16'h0, mon_e.data});
                check("word_mod", {28'h0, dmod}, {28'h0, mon_e.mod});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] data, input logic [3:0] m);
        exp_t e;
        e.data = data;
        e.mod  = m;
        sb_q.push_back(e);
    endtask

    // Drive len bits MSB-first; returns just after the edge that sampled the last bit.
    task automatic send_bits(input logic [15:0] bits, input int len);
        for (int i = 0; i < len; i++) begin
            ser_v = 1'b1;
            ser_d = bits[15-i];
            tick();
        end
    endtask

    task automatic gap();
        ser_v = 1'b0;
        ser_d = 1'b0;
        tick();
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && (sb_q.size() != 0 || dval === 1'b1); i++) begin
            tick();
        end
        check("drain_queue_empty", sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got t=%0t expected < 200000", $time);
        $fatal(1);
    end

    initial begin
        int ov0;
        int x0;

        vecs[0] = '{bits: 16'hA5C3, len: 16, exp_data: 16'hA5C3, exp_mod: 4'd0};
        vecs[1] = '{bits: 16'hB000, len: 5,  exp_data: 16'hB000, exp_mod: 4'd5};
        vecs[2] = '{bits: 16'h8000, len: 1,  exp_data: 16'h8000, exp_mod: 4'd1};
        vecs[3] = '{bits: 16'hFFFE, len: 15, exp_data: 16'hFFFE, exp_mod: 4'd15};
        vecs[4] = '{bits: 16'h3C00, len: 8,  exp_data: 16'h3C00, exp_mod: 4'd8};
        vecs[5] = '{bits: 16'h0001, len: 16, exp_data: 16'h0001, exp_mod: 4'd0};
        vecs[6] = '{bits: 16'h4000, len: 2,  exp_data: 16'h4000, exp_mod: 4'd2};

        srst  = 1'b1;
        ser_v = 1'b0;
        ser_d = 1'b0;
        rdy   = 1'b1;
        repeat (3) tick();
        check("rst_data", {16'h0, dout}, 32'h0);
        check("rst_mod", {28'h0, dmod}, 32'h0);
        check("rst_val", {31'h0, dval}, 32'h0);
        check("rst_ovf", {31'h0, ovf}, 32'h0);
        srst = 1'b0;
        tick();

        // Full word latency: valid exactly one cycle after bit 16.
        push_exp(16'hA5C3, 4'd0);
        send_bits(16'hA5C3, 15);
        check("full_val_before_last", {31'h0, dval}, 32'h0);
        ser_v = 1'b1;
        ser_d = 1'b1;
        tick();
        check("full_val_after_last", {31'h0, dval}, 32'h1);
        check("full_head_data", {16'h0, dout}, 32'h0000_A5C3);
        gap();
        wait_drain(20);

        // Short word latency: valid one cycle after the gap is sampled.
        push_exp(16'hB000, 4'd5);
        send_bits(16'hB000, 5);
        ser_v = 1'b0;
        check("short_val_before_gap", {31'h0, dval}, 32'h0);
        tick();
        check("short_val_after_gap", {31'h0, dval}, 32'h1);
        check("short_head_mod", {28'h0, dmod}, 32'd5);
        wait_drain(20);

        // Table of bursts, each followed by a one-cycle gap.
        for (int v = 0; v < 7; v++) begin
            push_exp(vecs[v].exp_data, vecs[v].exp_mod);
            send_bits(vecs[v].bits, vecs[v].len);
            gap();
            tick();
        end
        wait_drain(40);

        // Back-to-back bursts with no idle gap.
        push_exp(16'hFFFF, 4'd0);
        push_exp(16'h6000, 4'd3);
        send_bits(16'hFFFF, 16);
        send_bits(16'h6000, 3);
        gap();
        wait_drain(20);

        // Overflow: consumer stalled while three words arrive.
        rdy = 1'b0;
        x0  = xfer_cnt;
        push_exp(16'h9000, 4'd4);
        push_exp(16'h6000, 4'd4);
        send_bits(16'h9000, 4);
        gap();
        check("ovf_head1_data", {16'h0, dout}, 32'h9000);
        send_bits(16'h6000, 4);
        gap();
        check("ovf_head_stable_data", {16'h0, dout}, 32'h9000);
        check("ovf_head_stable_mod", {28'h0, dmod}, 32'd4);
        ov0 = ovf_cnt;
        send_bits(16'hF000, 4);
        ser_v = 1'b0;
        check("ovf_not_yet", {31'h0, ovf}, 32'h0);
        tick();
        check("ovf_pulse", {31'h0, ovf}, 32'h1);
        tick();
        check("ovf_pulse_end", {31'h0, ovf}, 32'h0);
        check("ovf_head_kept", {16'h0, dout}, 32'h9000);
        check("ovf_pulse_count", ovf_cnt - ov0, 1);
        rdy = 1'b1;
        wait_drain(20);
        tick();
        check("ovf_drained_two", xfer_cnt - x0, 2);
        check("ovf_val_after_drain", {31'h0, dval}, 32'h0);

        // Full FIFO with pop and push in the same cycle.
        rdy = 1'b0;
        push_exp(16'hA000, 4'd3);
        push_exp(16'h5000, 4'd4);
        push_exp(16'hC000, 4'd2);
        send_bits(16'hA000, 3);
        gap();
        send_bits(16'h5000, 4);
        gap();
        ov0 = ovf_cnt;
        send_bits(16'hC000, 2);
        ser_v = 1'b0;
        rdy   = 1'b1;
        tick();
        check("simul_no_ovf", {31'h0, ovf}, 32'h0);
        check("simul_next_head", {16'h0, dout}, 32'h5000);
        wait_drain(20);
        check("simul_ovf_count", ovf_cnt - ov0, 0);

        // Reset in the middle of a burst.
        x0 = xfer_cnt;
        send_bits(16'hABCD, 7);
        srst  = 1'b1;
        ser_v = 1'b0;
        tick();
        check("mrst_data", {16'h0, dout}, 32'h0);
        check("mrst_mod", {28'h0, dmod}, 32'h0);
        check("mrst_val", {31'h0, dval}, 32'h0);
        check("mrst_ovf", {31'h0, ovf}, 32'h0);
        srst = 1'b0;
        tick();
        tick();
        check("mrst_no_word", {31'h0, dval}, 32'h0);
        check("mrst_no_xfer", xfer_cnt - x0, 0);
        push_exp(16'h1234, 4'd0);
        send_bits(16'h1234, 16);
        gap();
        wait_drain(20);

        check("final_sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
